// File: rtl/fetch_unit.sv
// fetch_unit: LC2K multicycle fetch stage with PC, imem req/ack, decode valid/ready and sticky halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [2:0]  HALT_OPCODE = 3'b110
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_one,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] HOLD    = 3'd2;
  localparam logic [2:0] WAIT_PC = 3'd3;
  localparam logic [2:0] HALTED  = 3'd4;
  logic [2:0] state, state_nxt;
  logic       got_instr, accept, load_pc;
  always_comb begin
    got_instr = state == FETCH && imem_ack;
    accept    = state == HOLD && instr_ready;
    load_pc   = state == WAIT_PC && next_pc_valid;
    state_nxt = state == IDLE ? FETCH :
                got_instr ? HOLD :
                accept ? (instr[24:22] == HALT_OPCODE ? HALTED : WAIT_PC) :
                load_pc ? FETCH : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (got_instr) instr <= imem_rdata;
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (load_pc) pc <= next_pc;
    end
  end
  assign imem_req    = state == FETCH;
  assign instr_valid = state == HOLD;
  assign halted      = state == HALTED;
  assign imem_addr   = pc[15:0];
  assign pc_plus_one = pc + 32'd1;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_one;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        halted;
  logic [31:0] fetch_count;
  int          n_tests = 0;
  int          n_fail = 0;
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus_one(pc_plus_one), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
    .halted(halted), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " pc"}, pc, 32'd0);
    check({tag, " pc_plus_one"}, pc_plus_one, 32'd1);
    check({tag, " instr"}, instr, 32'd0);
    check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " fetch_count"}, fetch_count, 32'd0);
  endtask
  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    next_pc = '0; next_pc_valid = 1'b0;
    tick; tick;
    check_reset_vals("rst_held");
    reset = 1'b0;
    check_reset_vals("rst_first");
    tick;
    check("c2 req", {31'd0, imem_req}, 32'd1);
    check("c2 addr", {16'd0, imem_addr}, 32'd0);
    tick;
    check("c3 req", {31'd0, imem_req}, 32'd1);
    check("c3 valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0081_0001;
    tick;
    imem_ack = 1'b0;
    check("i1 valid", {31'd0, instr_valid}, 32'd1);
    check("i1 instr", instr, 32'h0081_0001);
    check("i1 req", {31'd0, imem_req}, 32'd0);
    check("i1 ppo", pc_plus_one, 32'd1);
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    check("acc1 count", fetch_count, 32'd1);
    check("wait valid a", {31'd0, instr_valid}, 32'd0);
    tick;
    check("wait valid b", {31'd0, instr_valid}, 32'd0);
    check("wait req", {31'd0, imem_req}, 32'd0);
    next_pc = 32'd5; next_pc_valid = 1'b1;
    tick;
    next_pc_valid = 1'b0;
    check("pc5", pc, 32'd5);
    check("addr5", {16'd0, imem_addr}, 32'd5);
    check("req5", {31'd0, imem_req}, 32'd1);
    check("ppo6", pc_plus_one, 32'd6);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("stall addr", {16'd0, imem_addr}, 32'd5);
      check("stall req", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick;
    imem_rdata = 32'hDEAD_BEEF; next_pc = 32'd9; next_pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold valid", {31'd0, instr_valid}, 32'd1);
      check("hold instr", instr, 32'h1234_5678);
      check("hold pc", pc, 32'd5);
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0; next_pc_valid = 1'b0;
    check("acc2 pc", pc, 32'd5);
    check("acc2 count", fetch_count, 32'd2);
    check("acc2 req", {31'd0, imem_req}, 32'd0);
    next_pc = 32'hFFFF_FFFF; next_pc_valid = 1'b1;
    tick;
    next_pc_valid = 1'b0;
    check("max addr", {16'd0, imem_addr}, 32'h0000_FFFF);
    check("max ppo", pc_plus_one, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0180_0000;
    tick;
    imem_ack = 1'b0;
    check("halt instr", instr, 32'h0180_0000);
    check("halt pre", {31'd0, halted}, 32'd0);
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    check("halted", {31'd0, halted}, 32'd1);
    check("halt count", fetch_count, 32'd3);
    check("halt valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      next_pc_valid = i[0]; next_pc = 32'd7; imem_ack = 1'b1; instr_ready = ~i[0];
      tick;
      check("hlt req", {31'd0, imem_req}, 32'd0);
      check("hlt sticky", {31'd0, halted}, 32'd1);
      check("hlt pc", pc, 32'hFFFF_FFFF);
      check("hlt count", fetch_count, 32'd3);
    end
    next_pc_valid = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_vals("rst_halt");
    tick;
    check("re req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    check_reset_vals("rst_fetch");
    tick;
    imem_ack = 1'b0;
    check("late req", {31'd0, imem_req}, 32'd1);
    check("late valid", {31'd0, instr_valid}, 32'd0);
    check("late instr", instr, 32'd0);
    check("late addr", {16'd0, imem_addr}, 32'd0);
    tick;
    check("late valid2", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0007;
    tick;
    imem_ack = 1'b0;
    check("refetch valid", {31'd0, instr_valid}, 32'd1);
    check("refetch instr", instr, 32'h0000_0007);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
